// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding, default data-memory size and the funct3 legality check.
package lsu_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned DMEM_BYTES_DEF = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Stores take B/H/W only; loads additionally take the unsigned BU/HU forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the big-endian memory word.
//   funct3     : access size / signedness
//   mem_word   : word read from memory (byte[addr] in [31:24])
//   store_data : LSB-aligned store data from the core
//   load_data  : extended load result
//   store_word : store data merged over mem_word (read-modify-write)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  // Addressed byte sits in the top lane, so extraction always uses the MSBs.
  always_comb begin
    load_data = '0;
    unique case (funct3)
      F3_B:    load_data = {{24{mem_word[31]}}, mem_word[31:24]};
      F3_BU:   load_data = {24'h0, mem_word[31:24]};
      F3_H:    load_data = {{16{mem_word[31]}}, mem_word[31:16]};
      F3_HU:   load_data = {16'h0, mem_word[31:16]};
      F3_W:    load_data = mem_word;
      default: load_data = '0;
    endcase
  end

  // Sub-word stores replace the top lanes and keep the remaining bytes.
  always_comb begin
    store_word = store_data;
    unique case (funct3)
      F3_B:    store_word = {store_data[7:0], mem_word[23:0]};
      F3_H:    store_word = {store_data[15:0], mem_word[15:0]};
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store initiator between execute stage and data memory.
//   req_*  : core request (accepted when req_valid & req_ready)
//   resp_* : one-cycle completion pulse with load data / fault flag
//   mem_*  : word-wide data-memory port; sub-word stores do read-modify-write
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int unsigned XLEN       = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_ren,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd,
  input  logic            mem_rdy
);

  // Every memory access touches four bytes, so the last legal base is size-4.
  localparam logic [XLEN-1:0] ADDR_MAX = XLEN'(DMEM_BYTES - 4);

  lsu_state_e      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_fault_q, resp_fault_d;
  logic            mem_ren_q, mem_ren_d;
  logic [XLEN-1:0] mem_wd_q, mem_wd_d;

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] store_word;
  logic            req_fault;

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .mem_word   (mem_rd),
    .store_data (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  assign req_fault = (req_addr > ADDR_MAX) || !f3_legal(req_we, req_funct3);

  // Next-state and next-output logic; strobes and response are registered.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    mem_ren_d    = 1'b0;
    mem_wd_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_fault) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else if (req_we && (req_funct3 == F3_W)) begin
            state_d  = ST_WR;
            mem_wd_d = req_wdata;
          end else begin
            // Loads and sub-word stores both need the current word first.
            state_d   = ST_RD;
            mem_ren_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        mem_ren_d = 1'b1;
        if (mem_rdy) begin
          mem_ren_d = 1'b0;
          if (we_q) begin
            state_d  = ST_WR;
            mem_wd_d = store_word;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
          end
        end
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wd_q     <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      mem_ren_q    <= mem_ren_d;
      mem_wd_q     <= mem_wd_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  // Gated by rst so a reset arriving during the write cycle suppresses it.
  assign mem_wen    = (state_q == ST_WR) & ~rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_ren    = mem_ren_q;
  assign mem_addr   = addr_q;
  assign mem_wd     = mem_wd_q;

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Core-side load/store initiator that drives the data-memory request interface (mem_ren/mem_wen/mem_addr/mem_wd, returning mem_rd/mem_rdy).
- Translates RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word-wide memory transactions.
- Sub-word stores use read-modify-write.
- Sits between the execute stage and the data memory, and stalls the core through req_ready.

Parameters:
DMEM_BYTES, 256, byte capacity of data memory; any access touching bytes past DMEM_BYTES-1 faults
XLEN, 32, data/address width (fixed at 32; present for readability)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  core presents a memory op
req_ready  out  1  high only in IDLE; op accepted on edge where req_valid&req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, extended; 0 for stores and faults
resp_fault  out  1  qualified by resp_valid; range or funct3 error
mem_ren  out  1  memory read strobe
mem_wen  out  1  memory write strobe
mem_addr  out  32  latched request address
mem_wd  out  32  write word (big-endian lanes)
mem_rd  in  32  read word: byte[addr] in [31:24], byte[addr+3] in [7:0]
mem_rdy  in  1  read data valid this cycle (may be combinational from mem_ren)

Behaviour:
- Reset and outputs:
  - Reset (sampled at edge) forces IDLE. All registered outputs become 0; pending op is dropped with no response.
  - mem_wen = (state==WR) & ~rst, so a reset asserted during WR blocks the write.
- FSM states: IDLE, RD, WR, RESP.
- Transitions from IDLE on accept:
  - Fault → RESP. Fault conditions: req_addr > DMEM_BYTES-4 (memory always touches 4 bytes), or funct3 illegal for direction (loads: 011/110/111; stores: anything but 000/001/010).
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- RD:
  - mem_ren=1 and waits any number of cycles for mem_rdy.
  - On the edge with mem_rdy=1, mem_rd is captured. Load → RESP; SB/SH → WR.
- WR: mem_wen=1 for exactly one cycle, then → RESP.
- RESP: resp_valid=1 for one cycle, then → IDLE. The next request is accepted at the earliest on the following edge (req_ready rises the cycle after RESP).
- Request latching: all request fields are latched at accept; req_* changes afterwards are ignored.
- Latency with zero-wait mem_rdy (accept edge = 0): resp_valid high in cycle 2 for loads and SW, cycle 3 for SB/SH, cycle 1 for faults.
- Load extraction from the captured word w:
  - B = sext(w[31:24]); BU = zext(w[31:24]).
  - H = sext(w[31:16]); HU = zext(w[31:16]).
  - W = w.
- Store merge: SW mem_wd = req_wdata; SH = {req_wdata[15:0], w[15:0]}; SB = {req_wdata[7:0], w[23:0]}.
- Idle bus values: mem_wd is 0 outside WR. mem_addr holds the last latched address (0 after reset).
- Alignment: no alignment is required; any address ≤ DMEM_BYTES-4 is legal.
- Faults issue no memory strobes.

Decomposition:
- Shared package lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU), 2-bit state encoding, DMEM_BYTES default.
- One combinational sub-module lsu_lane_align: inputs funct3, mem word and store data; outputs extended load data and merged store word.
- The FSM and latches stay in lsu_dmem_ctrl.

Test Plan:
- Reset, then SW addr=0x10 wdata=0x11223344 → mem_wen one cycle with mem_wd=0x11223344; resp_valid at cycle 2, fault=0.
- LW 0x10 → resp_rdata=0x11223344. LB 0x10 with memory byte 0x80 → 0xFFFFFF80. LBU → 0x00000080. LH 0x10 with bytes 0x80,0x01 → 0xFFFF8001. LHU → 0x00008001.
- SB addr=0x11 wdata=0x000000AA over word 0x11223344 at 0x11 (bytes 0x22,0x33,0x44,0x55) → RD then WR with mem_wd=0xAA334455; resp_valid at cycle 3. Subsequent LW 0x10 → 0x11AA3344.
- mem_rdy held low 5 cycles during a LW → FSM stays in RD with mem_ren=1 throughout and req_ready=0; resp_valid 1 cycle after mem_rdy rises.
- LW addr=0xFD (DMEM_BYTES=256) and store funct3=100 → resp_fault=1 at cycle 1, rdata=0, no mem_ren/mem_wen.
- rst asserted during the WR cycle of SB → no write lands (later LW shows old word); outputs 0; no resp_valid; IDLE next cycle.
